// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: shares one LCD_Controller byte-write port among N_REQ
// requesters. After reset it runs the HD44780 power-up words itself, then
// serves requesters round-robin. A grant stays locked to its owner until the
// owner presents a word flagged last, so multi-character messages stay whole.
//
// Controller handshake: oLCD_Start is held high with oLCD_DATA/oLCD_RS stable
// from the SEND cycle until the cycle in which iLCD_Done is sampled high. Start
// drops on the following edge. iLCD_Done is ignored while no write is pending.
// Every write is followed by DLY_CYC settle cycles before the next action.
module lcd_write_arbiter #(
  parameter int N_REQ   = 3,
  parameter int DLY_CYC = 262142,
  parameter int DLY_W   = 18
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [N_REQ-1:0]   iREQ,
  input  logic [9*N_REQ-1:0] iWORD,
  input  logic [N_REQ-1:0]   iLAST,
  output logic [N_REQ-1:0]   oACK,
  output logic [N_REQ-1:0]   oGNT,
  output logic               oBUSY,
  output logic               oINIT_DONE,
  output logic [7:0]         oLCD_DATA,
  output logic               oLCD_RS,
  output logic               oLCD_Start,
  input  logic               iLCD_Done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYC - 1);
  localparam logic [IW-1:0]    OWN_MAX  = IW'(N_REQ - 1);
  localparam logic [2:0]       INIT_MAX = 3'd4;

  typedef enum logic [2:0] {
    S_INIT_LOAD = 3'd0,
    S_SEND      = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_SETTLE    = 3'd3,
    S_ACK       = 3'd4,
    S_IDLE      = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       init_idx;
  logic [IW-1:0]    rr_ptr, owner, owner_inc, pick_idx, cand;
  logic [IW:0]      sum;
  logic [N_REQ-1:0] pick_oh, gnt_r;
  logic             pick_valid, locked, last_word, settle_done;
  logic             init_done_r, busy_r, rs_r;
  logic [DLY_W-1:0] dly_cnt;
  logic [7:0]       data_r;
  logic [8:0]       init_word;
  logic [8:0]       words [N_REQ];

  // Fixed power-up command list, all with RS=0.
  always_comb begin
    case (init_idx)
      3'd0:    init_word = 9'h038;
      3'd1:    init_word = 9'h00C;
      3'd2:    init_word = 9'h001;
      3'd3:    init_word = 9'h006;
      default: init_word = 9'h080;
    endcase
  end

  // Split the flat word bus into one {RS, data} entry per requester.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) words[i] = iWORD[9*i +: 9];
  end

  // Round-robin pick: first asserted request scanning upward from rr_ptr with wrap.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_oh    = '0;
    sum        = '0;
    cand       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      cand = sum[IW-1:0];
      if (iREQ[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh[pick_idx] = pick_valid;
  end

  assign owner_inc   = (owner == OWN_MAX) ? '0 : owner + IW'(1);
  assign settle_done = (dly_cnt == DLY_LAST);

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_INIT_LOAD;
    else         state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_INIT_LOAD: state_nx = S_SEND;
      S_SEND:      state_nx = S_WAIT_DONE;
      S_WAIT_DONE: if (iLCD_Done) state_nx = S_SETTLE;
      S_SETTLE: begin
        if (settle_done) begin
          if (!init_done_r) state_nx = (init_idx == INIT_MAX) ? S_IDLE : S_INIT_LOAD;
          else              state_nx = S_ACK;
        end
      end
      S_ACK:       state_nx = S_IDLE;
      S_IDLE: begin
        if (locked) begin
          if (iREQ[owner]) state_nx = S_SEND;
        end else if (pick_valid) begin
          state_nx = S_SEND;
        end
      end
      default:     state_nx = S_INIT_LOAD;
    endcase
  end

  // Datapath: word capture, grant/lock bookkeeping, settle counter, init progress.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      init_idx    <= '0;
      rr_ptr      <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      last_word   <= 1'b0;
      gnt_r       <= '0;
      dly_cnt     <= '0;
      data_r      <= '0;
      rs_r        <= 1'b0;
      init_done_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      busy_r <= (state_nx != S_IDLE);
      case (state)
        S_INIT_LOAD: begin
          rs_r   <= init_word[8];
          data_r <= init_word[7:0];
        end
        S_SETTLE: begin
          if (settle_done) begin
            dly_cnt <= '0;
            if (!init_done_r) begin
              if (init_idx == INIT_MAX) init_done_r <= 1'b1;
              else                      init_idx    <= init_idx + 3'd1;
            end
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        S_ACK: begin
          if (last_word) begin
            locked <= 1'b0;
            gnt_r  <= '0;
            rr_ptr <= owner_inc;
          end
        end
        S_IDLE: begin
          if (locked) begin
            if (iREQ[owner]) begin
              {rs_r, data_r} <= words[owner];
              last_word      <= iLAST[owner];
            end else begin
              locked <= 1'b0;
              gnt_r  <= '0;
              rr_ptr <= owner_inc;
            end
          end else if (pick_valid) begin
            owner          <= pick_idx;
            locked         <= 1'b1;
            gnt_r          <= pick_oh;
            {rs_r, data_r} <= words[pick_idx];
            last_word      <= iLAST[pick_idx];
          end
        end
        default: ;
      endcase
    end
  end

  assign oLCD_Start = (state == S_SEND) || (state == S_WAIT_DONE);
  assign oACK       = (state == S_ACK) ? gnt_r : '0;
  assign oGNT       = gnt_r;
  assign oBUSY      = busy_r;
  assign oINIT_DONE = init_done_r;
  assign oLCD_DATA  = data_r;
  assign oLCD_RS    = rs_r;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: drives lcd_write_arbiter with a behavioural LCD
// controller and per-requester word queues, checking every controller write,
// every ack pulse and its timing against expectations built by the bench.
module tb_lcd_write_arbiter;

  localparam int N        = 3;
  localparam int DLY      = 4;
  localparam int DONE_LAT = 3;

  typedef struct packed {
    logic [2:0] mask;
    logic [1:0] o0;
    logic [1:0] o1;
    logic [1:0] o2;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [9*N-1:0] word = '0;
  logic [N-1:0]   last = '0;
  logic           lcd_done = 1'b0;
  logic [N-1:0]   ack, gnt;
  logic           busy, init_done, lcd_rs, lcd_start;
  logic [7:0]     lcd_data;

  lcd_write_arbiter #(.N_REQ(N), .DLY_CYC(DLY), .DLY_W(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iWORD(word), .iLAST(last),
    .oACK(ack), .oGNT(gnt), .oBUSY(busy), .oINIT_DONE(init_done),
    .oLCD_DATA(lcd_data), .oLCD_RS(lcd_rs), .oLCD_Start(lcd_start),
    .iLCD_Done(lcd_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, done_cyc = 0, ctl_cnt = 0, writes_seen = 0, mptr = 0;
  logic start_q = 1'b0, spur = 1'b0, init_mode = 1'b0, init_first = 1'b0;
  logic [11:0]  exp_q [$];
  logic [N-1:0] ack_q [$];
  logic [9:0]   rq [N][$];
  logic [9:0]   mq [N][$];
  logic [8:0]   init_tab [5];
  vec_t         vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [8:0] vw(input int v, input int i);
    return 9'h140 + 9'(v*4 + i);
  endfunction

  // One clock cycle: observe outputs, run the LCD controller model, drive requesters.
  task automatic tick();
    logic [9:0] f;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (lcd_start && !start_q) begin
        writes_seen++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL write_unexpected: got %0h expected none (cycle %0d)", {gnt, lcd_rs, lcd_data}, cyc);
        end else begin
          chk("write", 32'({gnt, lcd_rs, lcd_data}), 32'(exp_q.pop_front()));
        end
        if (init_mode && !init_first) chk("init_gap", cyc - done_cyc, DLY + 2);
        init_first = 1'b0;
      end
      if (ack != '0) begin
        if (ack_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL ack_unexpected: got %0h expected none (cycle %0d)", ack, cyc);
        end else begin
          chk("ack_owner", 32'(ack), 32'(ack_q.pop_front()));
          chk("ack_delay", cyc - done_cyc, 1 + DLY);
        end
      end
    end
    start_q = lcd_start;
    if (lcd_start) begin
      ctl_cnt++;
      if (ctl_cnt == DONE_LAT) begin
        lcd_done = 1'b1;
        done_cyc = cyc;
      end else begin
        lcd_done = 1'b0;
      end
    end else begin
      ctl_cnt  = 0;
      lcd_done = spur;
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      if (rq[i].size() > 0) begin
        f = rq[i][0];
        req[i] = 1'b1;
        word[9*i +: 9] = f[8:0];
        last[i] = f[9];
      end else begin
        req[i] = 1'b0;
        word[9*i +: 9] = 9'h000;
        last[i] = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input logic lst, input logic [8:0] w);
    rq[r].push_back({lst, w});
  endtask

  task automatic expect_word(input int r, input logic [8:0] w);
    exp_q.push_back({oh(r), w});
    ack_q.push_back(oh(r));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_vec++; n_bad++;
      $display("FAIL %s: timeout, got %0d writes and %0d acks outstanding expected 0", name, exp_q.size(), ack_q.size());
    end
  endtask

  task automatic run_init();
    int k;
    init_mode = 1'b1;
    init_first = 1'b1;
    writes_seen = 0;
    for (int i = 0; i < 5; i++) exp_q.push_back({3'b000, init_tab[i]});
    rst_n = 1'b1;
    tick();
    tick();
    chk("init_busy", 32'({busy, init_done}), 32'h2);
    k = 0;
    while (!init_done && k < 400) begin
      tick();
      k++;
    end
    if (k >= 400) begin
      n_vec++; n_bad++;
      $display("FAIL init_timeout: got init_done=0 expected 1");
    end
    tick();
    chk("init_writes", writes_seen, 5);
    chk("init_done", 32'(init_done), 32'h1);
    chk("init_idle", 32'({gnt, busy}), 32'h0);
    chk("init_exp_left", exp_q.size(), 0);
    init_mode = 1'b0;
  endtask

  initial begin
    init_tab[0] = 9'h038; init_tab[1] = 9'h00C; init_tab[2] = 9'h001;
    init_tab[3] = 9'h006; init_tab[4] = 9'h080;
    // {request mask, expected grant order}; pointer evolves 0,2,1,1,1,1,1,1,0,0,2.
    vt[0] = '{3'b010, 2'd1, 2'd0, 2'd0};
    vt[1] = '{3'b001, 2'd0, 2'd0, 2'd0};
    vt[2] = '{3'b101, 2'd2, 2'd0, 2'd0};
    vt[3] = '{3'b101, 2'd2, 2'd0, 2'd0};
    vt[4] = '{3'b111, 2'd1, 2'd2, 2'd0};
    vt[5] = '{3'b111, 2'd1, 2'd2, 2'd0};
    vt[6] = '{3'b011, 2'd1, 2'd0, 2'd0};
    vt[7] = '{3'b110, 2'd1, 2'd2, 2'd0};
    vt[8] = '{3'b100, 2'd2, 2'd0, 2'd0};
    vt[9] = '{3'b011, 2'd0, 2'd1, 2'd0};

    repeat (3) tick();
    chk("reset_outputs", 32'({ack, gnt, busy, init_done, lcd_data, lcd_rs, lcd_start}), 32'h0);
    run_init();

    for (int v = 0; v < 10; v++) begin
      int cnt;
      logic [1:0] ord [3];
      cnt = $countones(vt[v].mask);
      ord[0] = vt[v].o0; ord[1] = vt[v].o1; ord[2] = vt[v].o2;
      for (int i = 0; i < N; i++) if (vt[v].mask[i]) load(i, 1'b1, vw(v, i));
      for (int j = 0; j < cnt; j++) expect_word(int'(ord[j]), vw(v, int'(ord[j])));
      tick();
      tick();
      chk("grant_start", 32'({gnt, lcd_start}), 32'({oh(int'(ord[0])), 1'b1}));
      wait_drain(400, "table_drain");
      chk("gnt_release", 32'(gnt), 32'h0);
    end

    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    tick();
    chk("spurious_done", 32'({busy, gnt, lcd_start, ack}), 32'h0);

    load(0, 1'b0, 9'h153); load(0, 1'b0, 9'h175); load(0, 1'b1, 9'h162);
    expect_word(0, 9'h153); expect_word(0, 9'h175); expect_word(0, 9'h162);
    tick();
    tick();
    chk("burst_grant", 32'(gnt), 32'h1);
    load(2, 1'b1, 9'h1AA);
    expect_word(2, 9'h1AA);
    wait_drain(400, "burst_drain");
    chk("burst_release", 32'(gnt), 32'h0);

    load(0, 1'b0, 9'h1D0);
    load(2, 1'b1, 9'h1D2);
    expect_word(0, 9'h1D0);
    expect_word(2, 9'h1D2);
    wait_drain(400, "drop_drain");
    chk("drop_release", 32'(gnt), 32'h0);

    load(1, 1'b1, 9'h1EE);
    exp_q.push_back({oh(1), 9'h1EE});
    tick();
    tick();
    tick();
    chk("pre_reset_wait", 32'({gnt, lcd_start}), 32'({oh(1), 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_write", 32'({ack, gnt, busy, init_done, lcd_data, lcd_rs, lcd_start}), 32'h0);
    for (int i = 0; i < N; i++) rq[i].delete();
    exp_q.delete();
    ack_q.delete();
    tick();
    tick();
    run_init();

    mptr = 0;
    for (int rnd = 0; rnd < 8; rnd++) begin
      int total, sel, nb, len;
      logic [9:0] e;
      logic [8:0] wd;
      total = 0;
      for (int i = 0; i < N; i++) begin
        nb = $urandom_range(0, 2);
        for (int b = 0; b < nb; b++) begin
          len = $urandom_range(1, 3);
          for (int w = 0; w < len; w++) begin
            wd = 9'($urandom_range(0, 511));
            e = {(w == len - 1), wd};
            rq[i].push_back(e);
            mq[i].push_back(e);
            total++;
          end
        end
      end
      while (total > 0) begin
        sel = -1;
        for (int k = 0; k < N; k++) begin
          if (sel < 0 && mq[(mptr + k) % N].size() > 0) sel = (mptr + k) % N;
        end
        do begin
          e = mq[sel].pop_front();
          expect_word(sel, e[8:0]);
          total--;
        end while (!e[9]);
        mptr = (sel + 1) % N;
      end
      wait_drain(3000, "random_drain");
      chk("random_gnt_idle", 32'(gnt), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
